// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse receive timer bank.
//   timer_state_t  : one-hot per-timer state
//   CLKS_PER_MS    : clk_100MHz cycles in one millisecond
//   DEFAULT_*      : default timer durations in 1 ms ticks
package morse_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'b001,
      RUN     = 3'b010,
      EXPIRED = 3'b100
   } timer_state_t;

   localparam int CLKS_PER_MS          = 100000;
   localparam int DEFAULT_BTN_TO_TICKS = 2000;
   localparam int DEFAULT_DASH_TICKS   = 200;
   localparam int DEFAULT_INTER_TICKS  = 600;
   localparam int DEFAULT_WORD_TICKS   = 1400;

   // True when value is representable in an unsigned field of width w.
   function automatic bit fits_width(input int value, input int w);
      return (value >> w) == 0;
   endfunction

endpackage

// File: rtl/morse_timeout_ctr.sv
// One restartable timeout timer. Counts tick pulses after a res pulse and
// raises a sticky done once LIMIT ticks have been consumed.
//   clk_100MHz : system clock
//   reset      : synchronous, active-high reset
//   tick       : one-cycle timebase pulse
//   res        : restart pulse (wins over tick and over expiry)
//   done       : registered, high while the timer is EXPIRED
//
// state   | meaning
// IDLE    | never started since reset, done = 0
// RUN     | counting ticks, count in 0..LIMIT-1
// EXPIRED | LIMIT ticks consumed, done = 1 until res or reset
module morse_timeout_ctr
   import morse_pkg::*;
#(
   parameter int LIMIT = DEFAULT_DASH_TICKS,
   parameter int CNT_W = 12
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic tick,
   input  logic res,
   output logic done
);

   if (LIMIT < 1) begin : g_bad_limit
      $fatal(1, "morse_timeout_ctr: LIMIT must be >= 1");
   end
   if (!fits_width(LIMIT, CNT_W)) begin : g_bad_width
      $fatal(1, "morse_timeout_ctr: CNT_W too narrow for LIMIT");
   end

   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   timer_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (res) begin
         // Restart discards any tick in the same cycle, including the expiring one.
         state_d = RUN;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: ;
            RUN: begin
               if (tick) begin
                  // Count parks at LAST on expiry so it can never wrap.
                  if (cnt_q == LAST) state_d = EXPIRED;
                  else               cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            EXPIRED: ;
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      done_d = (state_d == EXPIRED);
   end

   assign done = done_q;

endmodule

// File: rtl/morse_timer_bank.sv
// Timeout timer bank feeding the Morse receive FSM. A free-running prescaler
// produces a 1 ms tick shared by four restartable timeout timers.
//   clk_100MHz   : system clock
//   reset        : synchronous, active-high reset
//   btn_to_res   : restart button-held timeout
//   dash_to_res  : restart dash threshold timer
//   inter_to_res : restart inter-character gap timer
//   word_to_res  : restart word gap timer
//   btn_to, dash_to, inter_to, word_to : sticky elapsed flags
//   tick_ms      : prescaler tick, one cycle wide
module morse_timer_bank
   import morse_pkg::*;
#(
   parameter int CLKS_PER_TICK = CLKS_PER_MS,
   parameter int BTN_TO_TICKS  = DEFAULT_BTN_TO_TICKS,
   parameter int DASH_TICKS    = DEFAULT_DASH_TICKS,
   parameter int INTER_TICKS   = DEFAULT_INTER_TICKS,
   parameter int WORD_TICKS    = DEFAULT_WORD_TICKS,
   parameter int CNT_W         = 12
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic btn_to_res,
   input  logic dash_to_res,
   input  logic inter_to_res,
   input  logic word_to_res,
   output logic btn_to,
   output logic dash_to,
   output logic inter_to,
   output logic word_to,
   output logic tick_ms
);

   if (CLKS_PER_TICK < 2) begin : g_bad_clks
      $fatal(1, "morse_timer_bank: CLKS_PER_TICK must be >= 2");
   end
   if (BTN_TO_TICKS < 1 || DASH_TICKS < 1 || INTER_TICKS < 1 || WORD_TICKS < 1) begin : g_bad_ticks
      $fatal(1, "morse_timer_bank: every *_TICKS must be >= 1");
   end
   if (DASH_TICKS >= BTN_TO_TICKS) begin : g_bad_dash
      $fatal(1, "morse_timer_bank: DASH_TICKS must be < BTN_TO_TICKS");
   end
   if (INTER_TICKS >= WORD_TICKS) begin : g_bad_inter
      $fatal(1, "morse_timer_bank: INTER_TICKS must be < WORD_TICKS");
   end
   if (!fits_width(BTN_TO_TICKS, CNT_W) || !fits_width(DASH_TICKS, CNT_W) ||
       !fits_width(INTER_TICKS, CNT_W) || !fits_width(WORD_TICKS, CNT_W)) begin : g_bad_cnt_w
      $fatal(1, "morse_timer_bank: CNT_W too narrow for a *_TICKS value");
   end

   localparam int              PRE_W    = $clog2(CLKS_PER_TICK);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_TICK - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             tick_q, tick_d;

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tick_q <= tick_d;
      end
   end

   always_comb begin
      tick_d = (pre_q == PRE_LAST);
      pre_d  = tick_d ? '0 : pre_q + PRE_W'(1);
   end

   assign tick_ms = tick_q;

   morse_timeout_ctr #(.LIMIT(BTN_TO_TICKS), .CNT_W(CNT_W)) u_btn_to (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .tick       (tick_q),
      .res        (btn_to_res),
      .done       (btn_to)
   );

   morse_timeout_ctr #(.LIMIT(DASH_TICKS), .CNT_W(CNT_W)) u_dash_to (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .tick       (tick_q),
      .res        (dash_to_res),
      .done       (dash_to)
   );

   morse_timeout_ctr #(.LIMIT(INTER_TICKS), .CNT_W(CNT_W)) u_inter_to (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .tick       (tick_q),
      .res        (inter_to_res),
      .done       (inter_to)
   );

   morse_timeout_ctr #(.LIMIT(WORD_TICKS), .CNT_W(CNT_W)) u_word_to (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .tick       (tick_q),
      .res        (word_to_res),
      .done       (word_to)
   );

endmodule
